multi_bank_pp_buffer: RTL and testbench
=======================================

MULTI_BANK_PP_BUFFER -- requirements
Module: multi_bank_pp_buffer

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 2, number of ping-pong banks (legal 2..8).
REQ-002 SHALL have parameter BANK_DEPTH, default 1024, words per bank (power of two, >=4).
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have parameter CNT_W, default $clog2(BANK_DEPTH)+1, fill-count width.
REQ-005 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: wr_valid  in  1  producer word valid (fed from DDR read FIFO-write stream); wr_data  in  DW  word; wr_last  in  1  closes current bank early; wr_ready  out  1  word accepted when wr_valid&wr_ready.
REQ-007 SHALL have ports: bank_valid  out  1  a full bank is owned by consumer; bank_id  out  $clog2(NUM_BANKS)  that bank; bank_count  out  CNT_W  words in it.
REQ-008 SHALL have ports: rd_en  in  1  read strobe; rd_addr  in  $clog2(BANK_DEPTH)  offset in owned bank; rd_data  out  DW  read word; rd_release  in  1  consumer returns owned bank.
REQ-009 SHALL have ports: full_banks  out  $clog2(NUM_BANKS)+1  occupancy; overrun  out  1  sticky error flag.

Function
REQ-010 Banks SHALL occupy one flat memory, physical address = bank*BANK_DEPTH + offset.
REQ-011 Write FSM SHALL have states W_FILL and W_STALL; W_FILL asserts wr_ready, W_STALL deasserts it.
REQ-012 In W_FILL each accepted word SHALL be written at wr_ptr of wr_bank, wr_ptr increments.
REQ-013 A bank SHALL close when the accepted word is number BANK_DEPTH or carries wr_last; its count (1..BANK_DEPTH) is latched, full_banks increments, wr_bank advances modulo NUM_BANKS, wr_ptr clears.
REQ-014 If after a close full_banks equals NUM_BANKS, FSM SHALL enter W_STALL; it returns to W_FILL the cycle after a release.
REQ-015 wr_last with no word accepted in the bank SHALL be ignored (no empty banks).
REQ-016 bank_valid SHALL be 1 whenever full_banks>0; bank_id = rd_bank, bank_count = latched count of rd_bank; banks handed over strictly in fill order.
REQ-017 rd_data SHALL present word (rd_bank, rd_addr) exactly 1 cycle after rd_en; rd_data holds otherwise.
REQ-018 rd_release with bank_valid SHALL decrement full_banks and advance rd_bank modulo NUM_BANKS; rd_release with bank_valid=0 SHALL be ignored and set overrun.
REQ-019 Close and release in the same cycle SHALL leave full_banks unchanged and keep wr_ready high.
REQ-020 wr_valid while wr_ready=0 SHALL set overrun; word is not written.
REQ-021 rd_addr >= bank_count SHALL return stale memory contents, no error flagged.
REQ-022 full_banks SHALL never exceed NUM_BANKS nor underflow.

Reset
REQ-023 On rst: state W_FILL, wr_bank=rd_bank=0, wr_ptr=0, full_banks=0, bank_valid=0, bank_id=0, bank_count=0, rd_data=0, overrun=0, wr_ready=1 after deassertion.
REQ-024 Reset mid-fill SHALL discard all partial and full banks; memory contents need not clear.

Structure
REQ-025 Shared package pp_buf_pkg SHALL hold the write-state enum and bank-index/count width functions.
REQ-026 Storage SHALL be one sub-module pp_bank_ram (simple dual-port, 1 write, 1 registered read, depth NUM_BANKS*BANK_DEPTH).
REQ-027 Control (pointers, counters, FSM) SHALL be in the top module, no other sub-modules.

Verification
REQ-028 NUM_BANKS=2, BANK_DEPTH=8: write 8 words 0x10..0x17 -> bank_valid=1, bank_id=0, bank_count=8; rd_addr 3 -> rd_data 0x13 next cycle.
REQ-029 Write 24 words, no release -> wr_ready drops after word 16, full_banks=2; extra wr_valid sets overrun; release -> wr_ready=1 next cycle, bank_id=1.
REQ-030 Write 3 words with wr_last on 3rd -> bank_count=3; lone wr_last afterwards -> full_banks unchanged.
REQ-031 full_banks=1, close bank 1 and release bank 0 same cycle -> full_banks=1, bank_id=1, no stall.
REQ-032 NUM_BANKS=4: 4x8 words, release in order -> bank_id 0,1,2,3,0; release with none valid -> overrun=1.
REQ-033 Assert rst during 5th word of bank 1 -> all outputs at reset values; next bank fills bank 0 from offset 0.

Source files
------------

// File: rtl/pp_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pp_buf_pkg
// Description : Shared write-state encoding and width helpers for the
//               multi-bank ping-pong buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package pp_buf_pkg;

    typedef enum logic [0:0] {
        W_FILL  = 1'b0,
        W_STALL = 1'b1
    } wr_state_e;

    function automatic int bank_idx_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    function automatic int occ_w(input int num_banks);
        return $clog2(num_banks) + 1;
    endfunction

    function automatic int cnt_w(input int bank_depth);
        return $clog2(bank_depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pp_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : pp_bank_ram
// Description : Simple dual-port RAM, one write port, one registered read port
//               whose output holds when no read is requested.
// Revision    : 1.0 - initial release
// ============================================================================
module pp_bank_ram #(
    parameter int DEPTH = 16,
    parameter int DW    = 32,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata_q;
    logic [DW-1:0] w_rdata_d;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read-during-write to the same address returns the old word.
    always_comb begin
        w_rdata_d = r_rdata_q;
        if (i_re) begin
            w_rdata_d = r_mem[i_raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata_q <= '0;
        end else begin
            r_rdata_q <= w_rdata_d;
        end
    end

    assign o_rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: rtl/multi_bank_pp_buffer.sv
`default_nettype none
// ============================================================================
// Module      : multi_bank_pp_buffer
// Description : N-bank ping-pong buffer over one flat RAM; producer fills banks
//               in rotation, consumer owns and releases them in fill order.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_bank_pp_buffer
    import pp_buf_pkg::*;
#(
    parameter int NUM_BANKS  = 2,
    parameter int BANK_DEPTH = 1024,
    parameter int DW         = 32,
    parameter int CNT_W      = cnt_w(BANK_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    input  logic [DW-1:0]                 wr_data,
    input  logic                          wr_last,
    output logic                          wr_ready,
    output logic                          bank_valid,
    output logic [$clog2(NUM_BANKS)-1:0]  bank_id,
    output logic [CNT_W-1:0]              bank_count,
    input  logic                          rd_en,
    input  logic [$clog2(BANK_DEPTH)-1:0] rd_addr,
    output logic [DW-1:0]                 rd_data,
    input  logic                          rd_release,
    output logic [$clog2(NUM_BANKS):0]    full_banks,
    output logic                          overrun
);

    localparam int c_BANK_W   = bank_idx_w(NUM_BANKS);
    localparam int c_OFF_W    = $clog2(BANK_DEPTH);
    localparam int c_OCC_W    = occ_w(NUM_BANKS);
    localparam int c_ADDR_W   = c_BANK_W + c_OFF_W;
    localparam int c_RAM_DEPTH = NUM_BANKS * BANK_DEPTH;

    localparam logic [c_BANK_W-1:0] c_LAST_BANK = c_BANK_W'(NUM_BANKS - 1);
    localparam logic [c_BANK_W-1:0] c_BANK_ONE  = c_BANK_W'(1);
    localparam logic [c_OFF_W-1:0]  c_LAST_PTR  = c_OFF_W'(BANK_DEPTH - 1);
    localparam logic [c_OFF_W-1:0]  c_PTR_ONE   = c_OFF_W'(1);
    localparam logic [c_OCC_W-1:0]  c_OCC_ONE   = c_OCC_W'(1);
    localparam logic [c_OCC_W-1:0]  c_OCC_PRE   = c_OCC_W'(NUM_BANKS - 1);
    localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);

    wr_state_e             r_state_q,    w_state_d;
    logic [c_BANK_W-1:0]   r_wr_bank_q,  w_wr_bank_d;
    logic [c_BANK_W-1:0]   r_rd_bank_q,  w_rd_bank_d;
    logic [c_OFF_W-1:0]    r_wr_ptr_q,   w_wr_ptr_d;
    logic [c_OCC_W-1:0]    r_full_q,     w_full_d;
    logic                  r_overrun_q,  w_overrun_d;
    logic [CNT_W-1:0]      r_count_q [NUM_BANKS];
    logic [CNT_W-1:0]      w_count_d [NUM_BANKS];

    logic w_wr_ready;
    logic w_bank_valid;
    logic w_accept;
    logic w_close;
    logic w_release;

    function automatic logic [c_BANK_W-1:0] next_bank(input logic [c_BANK_W-1:0] b);
        return (b == c_LAST_BANK) ? '0 : b + c_BANK_ONE;
    endfunction

    always_comb begin
        w_state_d    = r_state_q;
        w_wr_bank_d  = r_wr_bank_q;
        w_rd_bank_d  = r_rd_bank_q;
        w_wr_ptr_d   = r_wr_ptr_q;
        w_full_d     = r_full_q;
        w_overrun_d  = r_overrun_q;
        w_count_d    = r_count_q;

        w_wr_ready   = (r_state_q == W_FILL);
        w_bank_valid = (r_full_q != '0);
        w_accept     = wr_valid && w_wr_ready;
        w_close      = w_accept && (wr_last || (r_wr_ptr_q == c_LAST_PTR));
        w_release    = rd_release && w_bank_valid;

        if (w_accept) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_ONE;
        end
        if (w_close) begin
            w_count_d[r_wr_bank_q] = CNT_W'(r_wr_ptr_q) + c_CNT_ONE;
            w_wr_ptr_d             = '0;
            w_wr_bank_d            = next_bank(r_wr_bank_q);
        end
        if (w_release) begin
            w_rd_bank_d = next_bank(r_rd_bank_q);
        end

        case ({w_close, w_release})
            2'b10:   w_full_d = r_full_q + c_OCC_ONE;
            2'b01:   w_full_d = r_full_q - c_OCC_ONE;
            default: w_full_d = r_full_q;
        endcase

        if ((wr_valid && !w_wr_ready) || (rd_release && !w_bank_valid)) begin
            w_overrun_d = 1'b1;
        end

        // A simultaneous release frees the slot the closing bank would take.
        case (r_state_q)
            W_FILL: begin
                if (w_close && !w_release && (r_full_q == c_OCC_PRE)) begin
                    w_state_d = W_STALL;
                end
            end
            W_STALL: begin
                if (w_release) begin
                    w_state_d = W_FILL;
                end
            end
            default: w_state_d = W_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= W_FILL;
            r_wr_bank_q <= '0;
            r_rd_bank_q <= '0;
            r_wr_ptr_q  <= '0;
            r_full_q    <= '0;
            r_overrun_q <= 1'b0;
            r_count_q   <= '{default: '0};
        end else begin
            r_state_q   <= w_state_d;
            r_wr_bank_q <= w_wr_bank_d;
            r_rd_bank_q <= w_rd_bank_d;
            r_wr_ptr_q  <= w_wr_ptr_d;
            r_full_q    <= w_full_d;
            r_overrun_q <= w_overrun_d;
            r_count_q   <= w_count_d;
        end
    end

    pp_bank_ram #(
        .DEPTH (c_RAM_DEPTH),
        .DW    (DW),
        .AW    (c_ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_accept),
        .i_waddr ({r_wr_bank_q, r_wr_ptr_q}),
        .i_wdata (wr_data),
        .i_re    (rd_en),
        .i_raddr ({r_rd_bank_q, rd_addr}),
        .o_rdata (rd_data)
    );

    assign wr_ready   = w_wr_ready;
    assign bank_valid = w_bank_valid;
    assign bank_id    = r_rd_bank_q;
    assign bank_count = w_bank_valid ? r_count_q[r_rd_bank_q] : '0;
    assign full_banks = r_full_q;
    assign overrun    = r_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_bank_pp_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_bank_pp_buffer
// Description : Directed and randomized checks of the ping-pong buffer against
//               a queue-of-banks reference model; a second 4-bank instance
//               covers bank rotation.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multi_bank_pp_buffer;

    localparam int NA = 2;
    localparam int NB = 4;
    localparam int D  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 2-bank instance
    logic        rst, wr_valid, wr_last, rd_en, rd_release;
    logic [31:0] wr_data;
    logic [2:0]  rd_addr;
    logic        wr_ready, bank_valid, overrun;
    logic [0:0]  bank_id;
    logic [3:0]  bank_count;
    logic [31:0] rd_data;
    logic [1:0]  full_banks;

    // 4-bank instance
    logic        rst_b, wr_valid_b, wr_last_b, rd_en_b, rd_release_b;
    logic [31:0] wr_data_b;
    logic [2:0]  rd_addr_b;
    logic        wr_ready_b, bank_valid_b, overrun_b;
    logic [1:0]  bank_id_b;
    logic [3:0]  bank_count_b;
    logic [31:0] rd_data_b;
    logic [2:0]  full_banks_b;

    multi_bank_pp_buffer #(.NUM_BANKS(NA), .BANK_DEPTH(D), .DW(32)) dut_a (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready), .bank_valid(bank_valid), .bank_id(bank_id), .bank_count(bank_count),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_release(rd_release),
        .full_banks(full_banks), .overrun(overrun)
    );

    multi_bank_pp_buffer #(.NUM_BANKS(NB), .BANK_DEPTH(D), .DW(32)) dut_b (
        .clk(clk), .rst(rst_b), .wr_valid(wr_valid_b), .wr_data(wr_data_b), .wr_last(wr_last_b),
        .wr_ready(wr_ready_b), .bank_valid(bank_valid_b), .bank_id(bank_id_b), .bank_count(bank_count_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_release(rd_release_b),
        .full_banks(full_banks_b), .overrun(overrun_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a queue of closed-bank word counts, oldest first.
    int          m_q[$];
    int          m_cur;
    int          m_rdb;
    bit          m_ovr;
    logic [31:0] m_mem [NA*D];
    bit          m_wr  [NA*D];
    logic [31:0] m_rd;
    bit          m_rd_known;

    function automatic void m_reset();
        m_q.delete();
        m_cur      = 0;
        m_rdb      = 0;
        m_ovr      = 1'b0;
        m_rd       = '0;
        m_rd_known = 1'b1;
    endfunction

    function automatic void m_edge(input bit wv, input logic [31:0] wd, input bit wl,
                                   input bit re, input int ra, input bit rr);
        int  n     = m_q.size();
        bit  ready = (n < NA);
        bit  valid = (n > 0);
        int  wb    = (m_rdb + n) % NA;
        if (re) begin
            m_rd       = m_mem[m_rdb*D + ra];
            m_rd_known = m_wr[m_rdb*D + ra];
        end
        if ((wv && !ready) || (rr && !valid)) m_ovr = 1'b1;
        if (wv && ready) begin
            m_mem[wb*D + m_cur] = wd;
            m_wr[wb*D + m_cur]  = 1'b1;
            m_cur++;
            if (m_cur == D || wl) begin
                m_q.push_back(m_cur);
                m_cur = 0;
            end
        end
        if (rr && valid) begin
            void'(m_q.pop_front());
            m_rdb = (m_rdb + 1) % NA;
        end
    endfunction

    task automatic m_check();
        int n = m_q.size();
        chk("wr_ready",   32'(wr_ready),   32'(n < NA));
        chk("bank_valid", 32'(bank_valid), 32'(n > 0));
        chk("bank_id",    32'(bank_id),    32'(m_rdb));
        chk("bank_count", 32'(bank_count), (n > 0) ? 32'(m_q[0]) : 32'd0);
        chk("full_banks", 32'(full_banks), 32'(n));
        chk("overrun",    32'(overrun),    32'(m_ovr));
        if (m_rd_known) chk("rd_data", rd_data, m_rd);
    endtask

    task automatic step(input bit wv, input logic [31:0] wd, input bit wl,
                        input bit re, input int ra, input bit rr);
        wr_valid = wv; wr_data = wd; wr_last = wl;
        rd_en = re; rd_addr = 3'(ra); rd_release = rr;
        @(posedge clk);
        m_edge(wv, wd, wl, re, ra, rr);
        #1;
        m_check();
        wr_valid = 1'b0; wr_last = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
    endtask

    // Asserts reset between clock edges, checks reset values, releases it.
    task automatic reset_a();
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        m_check();
        chk("rst_valid", 32'(bank_valid), 32'd0);
        chk("rst_id",    32'(bank_id),    32'd0);
        chk("rst_count", 32'(bank_count), 32'd0);
        chk("rst_full",  32'(full_banks), 32'd0);
        chk("rst_rd",    rd_data,         32'd0);
        chk("rst_ovr",   32'(overrun),    32'd0);
        wr_valid = 1'b0; wr_last = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", 32'(wr_ready), 32'd1);
    endtask

    task automatic step_b(input bit wv, input logic [31:0] wd, input bit rr,
                          input bit re, input int ra);
        wr_valid_b = wv; wr_data_b = wd; rd_release_b = rr;
        rd_en_b = re; rd_addr_b = 3'(ra);
        @(posedge clk);
        #1;
        wr_valid_b = 1'b0; rd_release_b = 1'b0; rd_en_b = 1'b0;
    endtask

    initial begin
        rst = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
        rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
        rst_b = 1'b1; wr_valid_b = 1'b0; wr_data_b = '0; wr_last_b = 1'b0;
        rd_en_b = 1'b0; rd_addr_b = '0; rd_release_b = 1'b0;
        m_reset();
        #1;

        // First full bank and a one-cycle-latency read
        reset_a();
        for (int i = 0; i < 8; i++) step(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0, 0, 1'b0);
        chk("r028_valid", 32'(bank_valid), 32'd1);
        chk("r028_id",    32'(bank_id),    32'd0);
        chk("r028_count", 32'(bank_count), 32'd8);
        step(1'b0, '0, 1'b0, 1'b1, 3, 1'b0);
        chk("r028_rd", rd_data, 32'h13);

        // Both banks full: stall, overrun on extra write, release resumes
        reset_a();
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 0, 1'b0);
            if (i == 15) begin
                chk("r029_stall", 32'(wr_ready),   32'd0);
                chk("r029_full",  32'(full_banks), 32'd2);
            end
        end
        chk("r029_ovr", 32'(overrun), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0, 0, 1'b1);
        chk("r029_ready", 32'(wr_ready), 32'd1);
        chk("r029_id",    32'(bank_id),  32'd1);
        step(1'b0, '0, 1'b0, 1'b1, 0, 1'b0);
        chk("r029_rd", rd_data, 32'h108);

        // Early close with wr_last; lone wr_last is ignored
        reset_a();
        step(1'b1, 32'h20, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 32'h21, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 32'h22, 1'b1, 1'b0, 0, 1'b0);
        chk("r030_count", 32'(bank_count), 32'd3);
        step(1'b0, '0, 1'b1, 1'b0, 0, 1'b0);
        chk("r030_lone", 32'(full_banks), 32'd1);
        step(1'b1, 32'h23, 1'b1, 1'b0, 0, 1'b0);
        chk("r030_one", 32'(full_banks), 32'd2);

        // Close and release in the same cycle
        reset_a();
        for (int i = 0; i < 15; i++) step(1'b1, 32'h30 + 32'(i), 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 32'h3F, 1'b0, 1'b0, 0, 1'b1);
        chk("r031_full",  32'(full_banks), 32'd1);
        chk("r031_id",    32'(bank_id),    32'd1);
        chk("r031_ready", 32'(wr_ready),   32'd1);

        // Reset during the 5th word of bank 1 discards everything
        reset_a();
        for (int i = 0; i < 12; i++) step(1'b1, 32'h40 + 32'(i), 1'b0, 1'b0, 0, 1'b0);
        wr_valid = 1'b1; wr_data = 32'hDEAD;
        reset_a();
        for (int i = 0; i < 8; i++) step(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0, 0, 1'b0);
        chk("r033_full", 32'(full_banks), 32'd1);
        chk("r033_id",   32'(bank_id),    32'd0);
        step(1'b0, '0, 1'b0, 1'b1, 0, 1'b0);
        chk("r033_rd0", rd_data, 32'h50);

        // Reading past bank_count returns the old memory word
        reset_a();
        for (int i = 0; i < 3; i++) step(1'b1, 32'h60 + 32'(i), (i == 2), 1'b0, 0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 5, 1'b0);
        chk("stale_rd", rd_data, 32'h55);

        // Randomized traffic against the model
        reset_a();
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 2);
        end

        // 4-bank rotation
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        chk("b_rst_valid", 32'(bank_valid_b), 32'd0);
        for (int i = 0; i < 32; i++) step_b(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 0);
        chk("b_full",  32'(full_banks_b), 32'd4);
        chk("b_stall", 32'(wr_ready_b),   32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("b_id",    32'(bank_id_b),    32'(k));
            chk("b_count", 32'(bank_count_b), 32'd8);
            if (k == 2) begin
                step_b(1'b0, '0, 1'b0, 1'b1, 5);
                chk("b_rd", rd_data_b, 32'h215);
            end
            step_b(1'b0, '0, 1'b1, 1'b0, 0);
        end
        chk("b_wrap_id", 32'(bank_id_b),    32'd0);
        chk("b_empty",   32'(full_banks_b), 32'd0);
        chk("b_ready",   32'(wr_ready_b),   32'd1);
        chk("b_no_ovr",  32'(overrun_b),    32'd0);
        step_b(1'b0, '0, 1'b1, 1'b0, 0);
        chk("b_ovr",     32'(overrun_b),    32'd1);
        chk("b_no_uf",   32'(full_banks_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
